// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Bundles the request/response signals of serial_subtractor.
//   start       request strobe (master -> slave)
//   a, b        minuend / subtrahend, WIDTH bits (master -> slave)
//   borrow_in   initial borrow into bit 0 (master -> slave)
//   busy        operation in progress (slave -> master)
//   done        one-cycle completion pulse (slave -> master)
//   diff        result, WIDTH bits (slave -> master)
//   borrow_out  final borrow (slave -> master)
//   zero        diff == 0 (slave -> master)
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, zero
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Multi-cycle WIDTH-bit subtractor: {borrow_out, diff} = a - b - borrow_in,
// STEP bits per clock, LSB chunk first, through a registered borrow chain.
// Operation: IDLE -> RUN (N = WIDTH/STEP cycles) -> DONE (1 cycle) -> IDLE.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_subtractor_if.slave (start/a/b/borrow_in in,
//          busy/done/diff/borrow_out/zero out)
//
// Parameters:
//   WIDTH  operand/result width (>= 1)
//   STEP   bits per cycle, must divide WIDTH
//
// Build option:
//   SERIAL_SUB_SAT_EN  when defined, a final borrow of 1 forces diff to 0 and
//                      zero to 1 (borrow_out still reports 1). Timing is the
//                      same in both builds.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (STEP < 1 || WIDTH < 1 || (WIDTH % STEP) != 0) begin : g_param_check
        $error("serial_subtractor: STEP must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;        // minuend shift register, LSB chunk at bottom
    logic [WIDTH-1:0] b_q, b_d;        // subtrahend shift register
    logic             brw_q, brw_d;    // borrow carried between chunks
    logic [WIDTH-1:0] res_q, res_d;    // partial result, chunks enter at the top
    logic [WIDTH-1:0] diff_q, diff_d;  // visible result, loads only on DONE entry
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;

    // One chunk of subtraction with one extra bit to catch the borrow.
    logic [STEP:0]    chunk_full;
    logic [WIDTH-1:0] res_shift;
    logic             final_borrow;

    always_comb begin
        chunk_full   = {1'b0, a_q[STEP-1:0]} - {1'b0, b_q[STEP-1:0]} - (STEP+1)'(brw_q);
        // Shift the result right and drop the new chunk into the top STEP bits;
        // after N chunks the first chunk has reached bit 0.
        res_shift    = (res_q >> STEP) | (WIDTH'(chunk_full[STEP-1:0]) << (WIDTH - STEP));
        final_borrow = chunk_full[STEP];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.borrow_in;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> STEP;
                b_d   = b_q >> STEP;
                brw_d = final_borrow;
                res_d = res_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    // All three outputs update together so no partial result
                    // is ever visible.
                    bout_d  = final_borrow;
`ifdef SERIAL_SUB_SAT_EN
                    if (final_borrow) begin
                        diff_d = '0;
                        zero_d = 1'b1;
                    end else begin
                        diff_d = res_shift;
                        zero_d = (res_shift == '0);
                    end
`else
                    diff_d = res_shift;
                    zero_d = (res_shift == '0);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bout_q;
    assign bus.zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Two subtractors (WIDTH=8, STEP=1 and STEP=4) receive identical requests.
// Each accepted request pushes an arithmetic-model expectation (value and
// completion cycle) into a per-instance queue; a negedge monitor pops and
// compares whenever that instance raises done.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;
    localparam int W  = 8;
    localparam int N0 = 8;   // cycles per op, STEP=1
    localparam int N1 = 2;   // cycles per op, STEP=4

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [W-1:0] a_v   = '0;
    logic [W-1:0] b_v   = '0;
    logic         bin_v = 1'b0;

    serial_subtractor_if #(.WIDTH(W)) if0 ();
    serial_subtractor_if #(.WIDTH(W)) if1 ();

    assign if0.start = start;  assign if0.a = a_v;  assign if0.b = b_v;  assign if0.borrow_in = bin_v;
    assign if1.start = start;  assign if1.a = a_v;  assign if1.b = b_v;  assign if1.borrow_in = bin_v;

    serial_subtractor #(.WIDTH(W), .STEP(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    serial_subtractor #(.WIDTH(W), .STEP(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_done0 = 1'b0;
    logic prev_done1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin, input int done_cyc);
        exp_t e;
        int   r;
        r     = int'(a) - int'(b) - int'(bin);
        e.a   = a;
        e.b   = b;
        e.bin = bin;
        e.bo  = (r < 0);
        e.d   = W'((r + 256) % 256);
        e.z   = (e.d == '0);
`ifdef SERIAL_SUB_SAT_EN
        if (e.bo) begin
            e.d = '0;
            e.z = 1'b1;
        end
`endif
        e.cyc = done_cyc;
        return e;
    endfunction

    task automatic mon(input int k, input logic [W-1:0] d, input logic bo, input logic z,
                       input logic prev);
        exp_t e;
        chk($sformatf("dut%0d_done_pulse", k), {31'd0, prev}, 32'd0);
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_unexpected_done actual=1 required=0", k);
            return;
        end
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        $display("txn dut%0d a=%02h b=%02h bin=%0d -> diff=%02h bo=%0d zero=%0d cyc=%0d (exp %02h %0d %0d %0d)",
                 k, e.a, e.b, e.bin, d, bo, z, cyc, e.d, e.bo, e.z, e.cyc);
        chk($sformatf("dut%0d_diff", k),       {24'd0, d},  {24'd0, e.d});
        chk($sformatf("dut%0d_borrow_out", k), {31'd0, bo}, {31'd0, e.bo});
        chk($sformatf("dut%0d_zero", k),       {31'd0, z},  {31'd0, e.z});
        chk($sformatf("dut%0d_latency", k),    cyc,         e.cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n && if0.done) mon(0, if0.diff, if0.borrow_out, if0.zero, prev_done0);
        if (rst_n && if1.done) mon(1, if1.diff, if1.borrow_out, if1.zero, prev_done1);
        prev_done0 = if0.done;
        prev_done1 = if1.done;
    end

    function automatic logic both_idle();
        return !if0.busy && !if0.done && !if1.busy && !if1.done;
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int waited = 0;
        while (!both_idle()) begin
            @(negedge clk);
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout actual=busy required=idle");
                return;
            end
        end
        a_v   = a;
        b_v   = b;
        bin_v = bin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        q0.push_back(model(a, b, bin, cyc + N0));
        q1.push_back(model(a, b, bin, cyc + N1));
        a_v   = W'($urandom);
        b_v   = W'($urandom);
        bin_v = 1'($urandom);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy0"}, {31'd0, if0.busy},       32'd0);
        chk({tag, "_done0"}, {31'd0, if0.done},       32'd0);
        chk({tag, "_diff0"}, {24'd0, if0.diff},       32'd0);
        chk({tag, "_bo0"},   {31'd0, if0.borrow_out}, 32'd0);
        chk({tag, "_zero0"}, {31'd0, if0.zero},       32'd1);
        chk({tag, "_busy1"}, {31'd0, if1.busy},       32'd0);
        chk({tag, "_done1"}, {31'd0, if1.done},       32'd0);
        chk({tag, "_diff1"}, {24'd0, if1.diff},       32'd0);
        chk({tag, "_bo1"},   {31'd0, if1.borrow_out}, 32'd0);
        chk({tag, "_zero1"}, {31'd0, if1.zero},       32'd1);
    endtask

    initial begin
        int drain;
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        issue(8'h05, 8'h03, 1'b0);
        issue(8'h03, 8'h05, 1'b0);
        issue(8'h00, 8'h00, 1'b1);
        issue(8'hA5, 8'hA5, 1'b0);
        issue(8'h80, 8'h01, 1'b0);
        issue(8'h00, 8'h01, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1);
        issue(8'hFF, 8'h00, 1'b0);

        // A second start while both instances are running must be ignored.
        issue(8'h12, 8'h34, 1'b0);
        a_v   = 8'hFF;
        b_v   = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);

        // Reset in the middle of an operation: nothing may complete.
        issue(8'h77, 8'h11, 1'b1);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h40, 8'h3F, 1'b0);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        drain = 0;
        while ((q0.size() != 0 || q1.size() != 0) && drain < 50) begin
            @(negedge clk);
            drain++;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d/%0d pending required=0", q0.size(), q1.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
